// File: rtl/scan_test_sequencer.sv
// Scan-test sequencer for a multi-chain scan DUT.
// Streams (N+1)*CHAIN_LEN stimulus/expect beats. Shift-in of pattern k overlaps
// shift-out of pattern k-1. A single capture cycle separates groups.
// Miscompares are counted with saturation and collected in a sticky per-chain map.
// Optional feature macro: SCAN_SEQ_FIRST_FAIL_EN records the pattern index and
// bit position of the first miscompare in a session.
module scan_test_sequencer #(
  parameter int NUM_CHAINS = 7,
  parameter int CHAIN_LEN  = 32,
  parameter int PCNT_W     = 16
) (
  input  logic                         CK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PCNT_W-1:0]            num_patterns,
  input  logic                         pat_valid,
  output logic                         pat_ready,
  input  logic [NUM_CHAINS-1:0]        pat_si,
  input  logic [NUM_CHAINS-1:0]        pat_exp,
  input  logic [NUM_CHAINS-1:0]        pat_mask,
  output logic                         scan_en,
  output logic                         test_en,
  output logic                         chain_ce,
  output logic [NUM_CHAINS-1:0]        si,
  input  logic [NUM_CHAINS-1:0]        so,
  output logic                         busy,
  output logic                         done,
  output logic [PCNT_W-1:0]            fail_cnt,
  output logic [NUM_CHAINS-1:0]        fail_chain_map,
  output logic [PCNT_W-1:0]            first_fail_pat,
  output logic [$clog2(CHAIN_LEN)-1:0] first_fail_bit
);

  localparam int BIT_W = $clog2(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

  state_t                  state;
  logic [PCNT_W-1:0]       n_lat;
  logic [PCNT_W-1:0]       grp;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    accept;
  logic                    final_grp;
  logic                    last_bit;
  logic                    compare;
  logic [NUM_CHAINS-1:0]   mism;

  // Pin-level decode of the state register; abort blocks acceptance and
  // freezes the DUT clock in the cycle it is raised.
  always_comb begin
    final_grp = (grp == n_lat);
    last_bit  = (bit_cnt == BIT_W'(CHAIN_LEN - 1));
    pat_ready = (state == SHIFT) && !abort;
    accept    = pat_ready && pat_valid;
    scan_en   = (state == SHIFT);
    chain_ce  = !abort && (((state == SHIFT) && pat_valid) || (state == CAPTURE));
    test_en   = (state == SHIFT) || (state == CAPTURE);
    busy      = test_en;
    done      = (state == DONE);
    si        = ((state == SHIFT) && !final_grp) ? pat_si : '0;
    mism      = (so ^ pat_exp) & ~pat_mask;
    compare   = accept && (grp != '0) && (mism != '0);
  end

  // Session FSM with group/bit counters and miscompare accumulation.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      n_lat          <= '0;
      grp            <= '0;
      bit_cnt        <= '0;
      fail_cnt       <= '0;
      fail_chain_map <= '0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fail_cnt       <= '0;
            fail_chain_map <= '0;
            n_lat          <= num_patterns;
            grp            <= '0;
            bit_cnt        <= '0;
            state          <= (num_patterns == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (compare) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            fail_chain_map <= fail_chain_map | mism;
          end
          if (accept) begin
            if (last_bit) begin
              bit_cnt <= '0;
              if (final_grp) begin
                state <= DONE;
              end else begin
                grp   <= grp + 1'b1;
                state <= CAPTURE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        CAPTURE: state <= SHIFT;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_SEQ_FIRST_FAIL_EN
  logic ff_seen;

  // Capture the location of the first miscompare; grp-1 is the pattern being unloaded.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      ff_seen        <= 1'b0;
      first_fail_pat <= '0;
      first_fail_bit <= '0;
    end else if ((state == IDLE) && start) begin
      ff_seen        <= 1'b0;
      first_fail_pat <= '0;
      first_fail_bit <= '0;
    end else if (compare && !ff_seen) begin
      ff_seen        <= 1'b1;
      first_fail_pat <= grp - 1'b1;
      first_fail_bit <= bit_cnt;
    end
  end
`else
  assign first_fail_pat = '0;
  assign first_fail_bit = '0;
`endif

endmodule
